// File: rtl/reorder_logic_sequencer.sv
// Purpose: hands out in-order queue tags and drains the reorder selector strictly in allocation order.
// Latency: tag grant, valid/next and retire are combinational from the registered pointers; state updates on the next edge.
// Backpressure: alloc_ready_o drops when all tags are outstanding or while flushing; retire waits on out_ready_i and the head's status bit.
module reorder_logic_sequencer #(
  parameter int NUM_QUEUES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int SEL_WIDTH     = $clog2(NUM_QUEUES)
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 alloc_req_i,
  output logic                 alloc_ready_o,
  output logic [SEL_WIDTH-1:0] alloc_tag_o,
  input  logic [NUM_QUEUES-1:0] status_i,
  input  logic                 out_ready_i,
  output logic                 valid_o,
  output logic [SEL_WIDTH-1:0] next_o,
  output logic                 retire_o,
  output logic [SEL_WIDTH:0]   count_o,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int CW  = SEL_WIDTH + 1;
  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  C_FULL = CW'(NUM_QUEUES);
  localparam logic [WDW-1:0] C_TMO  = WDW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_WIDTH-1:0] r_alloc_ptr;
  logic [SEL_WIDTH-1:0] r_ret_ptr;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_count_nxt;
  logic [WDW-1:0]       r_wd;
  logic                 r_timeout;

  logic w_flushing;
  logic w_head;
  logic w_alloc;
  logic w_wd_hit;

  assign w_flushing = (r_state == S_FLUSH);
  assign w_head     = status_i[r_ret_ptr];

  assign alloc_ready_o = (r_count < C_FULL) & ~w_flushing;
  // A flush request outranks a simultaneous allocation even though ready is still shown.
  assign w_alloc       = alloc_req_i & alloc_ready_o & ~flush_i;
  assign alloc_tag_o   = r_alloc_ptr;

  assign valid_o   = (r_count != '0) & out_ready_i & ~w_flushing & ~flush_i;
  assign next_o    = r_ret_ptr;
  assign retire_o  = valid_o & w_head;
  assign count_o   = r_count;
  assign busy_o    = (r_state != S_IDLE);
  assign timeout_o = r_timeout;

  // Watchdog only fires when enabled and the head has been missing long enough.
  assign w_wd_hit = (TIMEOUT_CYCLES != 0) && (r_wd == C_TMO);

  // Outstanding count after this cycle's allocate/retire.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_alloc, retire_o})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state logic; flush wins from every state.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_alloc) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_count_nxt == '0)  w_state_nxt = S_IDLE;
          else if (w_wd_hit)      w_state_nxt = S_STALL;
        end
        S_STALL: begin
          if (w_count_nxt == '0)  w_state_nxt = S_IDLE;
          else if (retire_o)      w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Pointers, count and sticky timeout; the FLUSH cycle wipes them all.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_alloc_ptr <= '0;
      r_ret_ptr   <= '0;
      r_count     <= '0;
      r_timeout   <= 1'b0;
    end else if (w_flushing) begin
      r_alloc_ptr <= '0;
      r_ret_ptr   <= '0;
      r_count     <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_alloc)  r_alloc_ptr <= r_alloc_ptr + SEL_WIDTH'(1);
      if (retire_o) r_ret_ptr   <= r_ret_ptr + SEL_WIDTH'(1);
      r_count   <= w_count_nxt;
      r_timeout <= r_timeout | (w_state_nxt == S_STALL);
    end
  end

  // Head-stall counter: counts cycles the head entry is absent, saturating at the limit.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wd <= '0;
    end else if (w_flushing || retire_o || (r_count == '0)) begin
      r_wd <= '0;
    end else if (!w_head && (r_wd != C_TMO)) begin
      r_wd <= r_wd + WDW'(1);
    end
  end

endmodule

// File: tb/tb_reorder_logic_sequencer.sv
// Purpose: randomized and directed bench for reorder_logic_sequencer against a queue-based model.
// Latency: outputs compared every negedge; directed literals checked 3 time units after each rising edge.
// Backpressure: exercises full tag pool, missing head status, out_ready_i low and flush.
module tb_reorder_logic_sequencer;

  localparam int N = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       alloc_req;
  logic       alloc_ready_o;
  logic [1:0] alloc_tag_o;
  logic [3:0] status;
  logic       out_ready;
  logic       valid_o;
  logic [1:0] next_o;
  logic       retire_o;
  logic [2:0] count_o;
  logic       flush;
  logic       busy_o;
  logic       timeout_o;

  always #5 clk = ~clk;

  reorder_logic_sequencer #(.NUM_QUEUES(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .alloc_req_i  (alloc_req),
    .alloc_ready_o(alloc_ready_o),
    .alloc_tag_o  (alloc_tag_o),
    .status_i     (status),
    .out_ready_i  (out_ready),
    .valid_o      (valid_o),
    .next_o       (next_o),
    .retire_o     (retire_o),
    .count_o      (count_o),
    .flush_i      (flush),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding tags as a FIFO, next tag to hand out, head-missing streak,
  // sticky timeout and whether the current cycle is the one-cycle flush.
  int q[$];
  int m_next = 0;
  int m_wd   = 0;
  bit m_fl   = 1'b0;
  bit m_to   = 1'b0;

  int mc, mr, mn;
  bit mhd, mv, mret, ma;

  // Advance the model with the inputs present at each rising edge.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q.delete();
      m_next = 0; m_wd = 0; m_fl = 1'b0; m_to = 1'b0;
    end else begin
      mc = q.size();
      mr = (mc != 0) ? q[0] : m_next;
      if (m_fl) begin
        q.delete();
        m_next = 0; m_wd = 0; m_to = 1'b0;
        m_fl = flush;
      end else begin
        mhd  = status[mr];
        mv   = (mc != 0) && out_ready && !flush;
        mret = mv && mhd;
        ma   = alloc_req && (mc < N) && !flush;
        mn   = mc + int'(ma) - int'(mret);
        if (!flush && mc > 0 && m_wd == T && mn > 0) m_to = 1'b1;
        if (mret || mc == 0)          m_wd = 0;
        else if (!mhd && m_wd < T)    m_wd = m_wd + 1;
        if (mret) void'(q.pop_front());
        if (ma) begin
          q.push_back(m_next);
          m_next = (m_next + 1) % N;
        end
        m_fl = flush;
      end
    end
  end

  int ec, er;
  bit ev;

  // Compare every output against the model away from the rising edge.
  always @(negedge clk) begin
    if (arst_n === 1'b1 && chk_en) begin
      ec = q.size();
      er = (ec != 0) ? q[0] : m_next;
      ev = (ec != 0) && out_ready && !m_fl && !flush;
      chk("alloc_ready", alloc_ready_o, int'((ec < N) && !m_fl));
      chk("alloc_tag",   alloc_tag_o,   m_next);
      chk("valid",       valid_o,       int'(ev));
      chk("next",        next_o,        er);
      chk("retire",      retire_o,      int'(ev && status[er]));
      chk("count",       count_o,       ec);
      chk("busy",        busy_o,        int'(m_fl || ec != 0));
      chk("timeout",     timeout_o,     int'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_alloc_ready"}, alloc_ready_o, 1);
    chk({tag, "_alloc_tag"},   alloc_tag_o,   0);
    chk({tag, "_valid"},       valid_o,       0);
    chk({tag, "_next"},        next_o,        0);
    chk({tag, "_retire"},      retire_o,      0);
    chk({tag, "_count"},       count_o,       0);
    chk({tag, "_busy"},        busy_o,        0);
    chk({tag, "_timeout"},     timeout_o,     0);
  endtask

  bit ta[9]   = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  bit tor[9]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
  int ttag[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int k;
    arst_n = 1'b0; alloc_req = 1'b0; out_ready = 1'b0; status = 4'b0; flush = 1'b0;
    #2;
    chk_reset_vals("rst");
    #1 arst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Four back-to-back allocations, then a held fifth request.
    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk("t1_tag", alloc_tag_o, i);
      tick();
    end
    #2;
    chk("t1_count_full", count_o, 4);
    chk("t1_ready_full", alloc_ready_o, 0);
    chk("t1_busy", busy_o, 1);
    tick();
    #2;
    chk("t1_fifth_ignored", count_o, 4);
    tick();

    // Head must be present before anything retires; then in-order drain.
    alloc_req = 1'b0; out_ready = 1'b1; status = 4'b1000;
    #2 chk("t2_no_retire_a", retire_o, 0);
    tick();
    status = 4'b1100;
    #2 chk("t2_no_retire_b", retire_o, 0);
    tick();
    status = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t2_next", next_o, i);
      chk("t2_retire", retire_o, 1);
      tick();
    end
    #2;
    chk("t2_count_empty", count_o, 0);
    chk("t2_idle", busy_o, 0);
    tick();

    // Wrap-around with three simultaneous allocate+retire cycles.
    k = 0;
    for (int c = 0; c < 9; c++) begin
      alloc_req = ta[c]; out_ready = tor[c];
      #2;
      if (ta[c]) begin
        chk("t3_tag", alloc_tag_o, ttag[k]);
        k++;
      end
      tick();
    end
    alloc_req = 1'b0;
    #2 chk("t3_count_final", count_o, 0);
    tick();

    // Watchdog: one tag outstanding, head never present.
    status = 4'b0; out_ready = 1'b1; alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    repeat (8) tick();
    #2 chk("t4_timeout_before", timeout_o, 0);
    tick();
    #2 chk("t4_timeout_set", timeout_o, 1);
    tick();
    status = 4'b1111;
    tick();
    #2;
    chk("t4_timeout_sticky", timeout_o, 1);
    chk("t4_count_after_retire", count_o, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2;
    chk("t4_flush_busy", busy_o, 1);
    chk("t4_flush_ready", alloc_ready_o, 0);
    tick();
    #2 chk("t4_timeout_cleared", timeout_o, 0);
    tick();

    // Flush with three outstanding and a competing allocation.
    status = 4'b0; out_ready = 1'b0; alloc_req = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; alloc_req = 1'b0; out_ready = 1'b1;
    #2;
    chk("t5_no_alloc", count_o, 3);
    chk("t5_ready_low", alloc_ready_o, 0);
    chk("t5_valid_low", valid_o, 0);
    tick();
    #2;
    chk("t5_count_clr", count_o, 0);
    chk("t5_tag_clr", alloc_tag_o, 0);
    chk("t5_next_clr", next_o, 0);
    tick();

    // Randomized traffic with alternating head-starved phases.
    for (int c = 0; c < 3000; c++) begin
      alloc_req = ($urandom_range(0, 99) < 55);
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 199) == 0);
      status    = ((c / 150) % 3 == 2) ? 4'b0 : 4'($urandom_range(0, 15));
      tick();
    end

    // Asynchronous reset with two outstanding and timeout set.
    alloc_req = 1'b0; status = 4'b0; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    alloc_req = 1'b1;
    repeat (2) tick();
    alloc_req = 1'b0;
    repeat (10) tick();
    #2;
    chk("t6_pre_timeout", timeout_o, 1);
    chk("t6_pre_count", count_o, 2);
    arst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    #3 arst_n = 1'b1;
    tick();
    #2 chk("t6_post_count", count_o, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
